// File: rtl/tft_client_arbiter.sv
// Shares one tft_spi transmitter among N_CLIENTS draw clients: a one-shot boot
// client after reset, then round-robin grants of whole enable/busy transactions.
module tft_client_arbiter #(
    parameter int N_CLIENTS   = 3,
    parameter int ID_W        = 2,
    parameter int BOOT_CLIENT = 0,
    parameter int ARM_TIMEOUT = 16,
    parameter int RUN_TIMEOUT = 1048575,
    parameter int TO_W        = 20
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [N_CLIENTS-1:0]   req,
    input  logic [N_CLIENTS-1:0]   client_busy,
    input  logic [8*N_CLIENTS-1:0] client_data,
    input  logic [N_CLIENTS-1:0]   client_dc,
    input  logic [N_CLIENTS-1:0]   client_transmit,
    output logic [N_CLIENTS-1:0]   client_enable,
    input  logic                   spi_busy,
    output logic [7:0]             spi_data,
    output logic                   spi_dc,
    output logic                   spi_transmit,
    output logic [ID_W-1:0]        active_id,
    output logic                   boot_done,
    output logic                   timeout_err
);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ARM   = 3'd1,
        ST_RUN   = 3'd2,
        ST_DRAIN = 3'd3,
        ST_GAP   = 3'd4
    } state_t;

    localparam logic [ID_W-1:0] BOOT_ID    = ID_W'(BOOT_CLIENT);
    localparam logic [ID_W-1:0] PTR_INIT   = ID_W'(N_CLIENTS - 1);
    localparam logic [7:0]      ARM_LAST   = 8'(ARM_TIMEOUT - 1);
    localparam int              RUN_LAST_I = (RUN_TIMEOUT > 0) ? RUN_TIMEOUT - 1 : 0;
    localparam logic [TO_W-1:0] RUN_LAST   = TO_W'(RUN_LAST_I);
    localparam bit              RUN_TO_EN  = (RUN_TIMEOUT != 0);

    state_t               state_r, state_nx_s;
    logic [N_CLIENTS-1:0] enable_nx_s;
    logic [ID_W-1:0]      id_nx_s, ptr_r, ptr_nx_s, grant_id_s;
    logic [7:0]           arm_cnt_r, arm_cnt_nx_s;
    logic [TO_W-1:0]      run_cnt_r, run_cnt_nx_s;
    logic                 boot_nx_s, terr_nx_s, grant_s;
    logic [ID_W:0]        pick_s;

    function automatic logic [N_CLIENTS-1:0] onehot(input logic [ID_W-1:0] id);
        return {{(N_CLIENTS-1){1'b0}}, 1'b1} << id;
    endfunction

    // Scans from the farthest candidate to the nearest so the nearest eligible one wins.
    function automatic logic [ID_W:0] rr_pick(input logic [N_CLIENTS-1:0] r,
                                              input logic [ID_W-1:0]      p);
        logic [ID_W:0]   res;
        logic [ID_W-1:0] idx;
        res = {(ID_W+1){1'b0}};
        for (int i = N_CLIENTS; i >= 1; i--) begin
            idx = ID_W'((int'(p) + i) % N_CLIENTS);
            res = (r[idx] && (int'(idx) != BOOT_CLIENT)) ? {1'b1, idx} : res;
        end
        return res;
    endfunction

    // Grant candidate: the boot client until it has run once, then round-robin.
    always_comb begin
        pick_s = rr_pick(req, ptr_r);
        if (!boot_done) begin
            grant_s    = 1'b1;
            grant_id_s = BOOT_ID;
        end else begin
            grant_s    = pick_s[ID_W];
            grant_id_s = pick_s[ID_W-1:0];
        end
    end

    // Transaction FSM next-state and next register values.
    always_comb begin
        state_nx_s   = state_r;
        enable_nx_s  = client_enable;
        id_nx_s      = active_id;
        ptr_nx_s     = ptr_r;
        arm_cnt_nx_s = arm_cnt_r;
        run_cnt_nx_s = run_cnt_r;
        boot_nx_s    = boot_done;
        terr_nx_s    = timeout_err;
        case (state_r)
            ST_IDLE: begin
                if (grant_s) begin
                    state_nx_s   = ST_ARM;
                    id_nx_s      = grant_id_s;
                    ptr_nx_s     = grant_id_s;
                    enable_nx_s  = onehot(grant_id_s);
                    arm_cnt_nx_s = 8'd0;
                end else begin
                    enable_nx_s = {N_CLIENTS{1'b0}};
                end
            end
            ST_ARM: begin
                if (client_busy[active_id]) begin
                    state_nx_s   = ST_RUN;
                    run_cnt_nx_s = {TO_W{1'b0}};
                end else if (arm_cnt_r >= ARM_LAST) begin
                    // A client that never starts is an empty turn, not a fault.
                    state_nx_s  = ST_DRAIN;
                    enable_nx_s = {N_CLIENTS{1'b0}};
                end else begin
                    arm_cnt_nx_s = arm_cnt_r + 8'd1;
                end
            end
            ST_RUN: begin
                if (!client_busy[active_id]) begin
                    state_nx_s  = ST_DRAIN;
                    enable_nx_s = {N_CLIENTS{1'b0}};
                end else if (RUN_TO_EN && (run_cnt_r >= RUN_LAST)) begin
                    state_nx_s  = ST_DRAIN;
                    enable_nx_s = {N_CLIENTS{1'b0}};
                    terr_nx_s   = 1'b1;
                end else begin
                    run_cnt_nx_s = (run_cnt_r == {TO_W{1'b1}}) ? run_cnt_r : run_cnt_r + TO_W'(1);
                end
            end
            ST_DRAIN: begin
                enable_nx_s = {N_CLIENTS{1'b0}};
                if (!spi_busy) begin
                    state_nx_s = ST_GAP;
                    boot_nx_s  = boot_done | (active_id == BOOT_ID);
                end else begin
                    state_nx_s = ST_DRAIN;
                end
            end
            ST_GAP: begin
                enable_nx_s = {N_CLIENTS{1'b0}};
                state_nx_s  = ST_IDLE;
            end
            default: begin
                enable_nx_s = {N_CLIENTS{1'b0}};
                state_nx_s  = ST_IDLE;
            end
        endcase
    end

    // State and transaction registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r       <= ST_IDLE;
            client_enable <= {N_CLIENTS{1'b0}};
            active_id     <= {ID_W{1'b0}};
            ptr_r         <= PTR_INIT;
            arm_cnt_r     <= 8'd0;
            run_cnt_r     <= {TO_W{1'b0}};
            boot_done     <= 1'b0;
            timeout_err   <= 1'b0;
        end else begin
            state_r       <= state_nx_s;
            client_enable <= enable_nx_s;
            active_id     <= id_nx_s;
            ptr_r         <= ptr_nx_s;
            arm_cnt_r     <= arm_cnt_nx_s;
            run_cnt_r     <= run_cnt_nx_s;
            boot_done     <= boot_nx_s;
            timeout_err   <= terr_nx_s;
        end
    end

    // SPI mux: only the granted client's strobe passes, and only while it owns the bus.
    always_comb begin
        spi_data = client_data[{active_id, 3'b000} +: 8];
        spi_dc   = client_dc[active_id];
        if ((state_r == ST_ARM) || (state_r == ST_RUN)) begin
            spi_transmit = client_transmit[active_id];
        end else begin
            spi_transmit = 1'b0;
        end
    end

endmodule
